vx_gpr_bank_scheduler: RTL and testbench
========================================

// Module: vx_gpr_bank_scheduler
// PURPOSE
//  Schedules GPR read ports across NUM_BANKS single-read-port register banks shared by NUM_REQS operand requesters
//  (one per issue slot / collector). Per-bank round-robin grant, registers the bank read address, and returns a
//  fixed-latency response tag telling each requester which bank's rdata to capture. Sits between the operand
//  collectors and the VX_dp_ram GPR banks (OUT_REG=1).
// PARAMETERS
//  NUM_REQS   4  number of requesters (>=1, any value)
//  NUM_BANKS  4  number of GPR banks (power of two, >=1); bank = rid low bits
//  NR_BITS    6  register id width
//  WIS_BITS   2  warp-in-slot width (0 allowed -> no wis field in address)
//  BANK_W     = LOG2UP(NUM_BANKS); ADDRW = WIS_BITS + NR_BITS - log2(NUM_BANKS)
// PORTS
//  clk            in   1                  clock
//  reset_n        in   1                  synchronous, active-low reset
//  req_valid      in   NUM_REQS           read request per requester
//  req_wis        in   NUM_REQS*WIS_BITS  warp slot of request
//  req_rid        in   NUM_REQS*NR_BITS   register id of request
//  req_ready      out  NUM_REQS           grant (handshake completes when valid&ready)
//  bank_rd_en     out  NUM_BANKS          registered read enable per bank
//  bank_rd_addr   out  NUM_BANKS*ADDRW    registered read address {wis, rid[NR_BITS-1:log2(NUM_BANKS)]}
//  rsp_valid      out  NUM_REQS           read data for this requester is on bank rdata this cycle
//  rsp_bank       out  NUM_REQS*BANK_W    bank whose rdata to capture
//  rsp_zero       out  NUM_REQS           response is for r0; requester substitutes '0
//  perf_conflicts out  32                 cycles with >=1 valid request not granted
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): all outputs 0, rr pointers 0, pipeline stages cleared, perf_conflicts 0.
//    Reset mid-operation drops all in-flight grants; no rsp_valid follows a pre-reset grant.
//  - Handshake: requester holds valid and payload stable until ready. req_ready is combinational from
//    req_valid/req_rid and current rr pointers (no dependency on rsp side). A requester never blocks responses.
//  - Zero register: req_rid==0 is granted the same cycle regardless of bank contention; it uses no bank port
//    (no bank_rd_en) and returns rsp_valid with rsp_zero=1, rsp_bank=0.
//  - Arbitration per bank b: candidates = valid, rid!=0, rid[BANK_W-1:0]==b. Winner = first candidate
//    scanning from rr_ptr[b] upward, wrapping NUM_REQS-1 -> 0. At most one grant per bank per cycle;
//    different banks grant independently in the same cycle.
//  - Pointer update: on grant to k, rr_ptr[b] <= (k==NUM_REQS-1) ? 0 : k+1; unchanged with no grant.
//  - Latency (grant/handshake at cycle T):
//      T+1 bank_rd_en[b]=1, bank_rd_addr[b]=address of winner (address register stage);
//      T+2 rsp_valid[k]=1, rsp_bank[k]=b (RAM output register stage). Fixed, no stalls; pipelined,
//      one new grant per bank every cycle -> full throughput with no conflicts.
//  - bank_rd_addr holds last value when bank_rd_en=0 (no toggling); only bank_rd_en qualifies it.
//  - A requester has at most one request granted per cycle, so rsp_valid[k] is never doubly driven.
//  - NUM_BANKS=1: BANK_W=1, rsp_bank always 0, all non-zero rids contend for bank 0.
//  - WIS_BITS=0: address is rid[NR_BITS-1:log2(NUM_BANKS)] only.
//  - perf_conflicts: +1 per cycle where any req_valid&~req_ready; saturates at 32'hFFFF_FFFF.
//  - Writes are outside this block (separate dp_ram write port); read/write same-address ordering is the
//    RAM's (NO_RWCHECK) responsibility.
// TESTING (defaults NUM_REQS=4, NUM_BANKS=4, WIS_BITS=2)
//  1 req0 rid=5 wis=1 at T -> req_ready[0]=1 at T; T+1 bank_rd_en=4'b0010, bank_rd_addr[1]={2'd1,4'd1};
//    T+2 rsp_valid=4'b0001, rsp_bank[0]=1, rsp_zero[0]=0.
//  2 req0 rid=4, req1 rid=8 (both bank0), ptr0=0 -> T: ready=4'b0001, perf_conflicts=1; T+1: ready[1]=1,
//    bank_rd_addr[0] sequence {wis,1} then {wis,2}; responses at T+2 and T+3.
//  3 req0..3 rid=4,5,6,7 same cycle -> all ready at T, bank_rd_en=4'b1111 at T+1, rsp_valid=4'b1111 at T+2,
//    rsp_bank = 0,1,2,3; perf_conflicts unchanged.
//  4 all four reqs hold rid=2 (bank2) continuously, re-asserting after each grant -> grant order 0,1,2,3,0,1;
//    no requester waits more than 3 cycles.
//  5 req0 rid=0 while req1,req2 contend for bank0 -> req0 ready at T, no extra bank_rd_en, T+2
//    rsp_valid[0]=1 rsp_zero[0]=1; bank0 grants req1 then req2.
//  6 grant at T, reset_n=0 at T+1 -> bank_rd_en=0, rsp_valid=0 at T+2, perf_conflicts=0, next grant from ptr 0.

Source files
------------

// File: rtl/vx_gpr_bank_scheduler.sv
// Round-robin read-port scheduler for single-read-port GPR banks: per-bank grant,
// registered bank read address, and a fixed two-cycle response tag back to each requester.
module vx_gpr_bank_scheduler #(
    parameter int unsigned NUM_REQS  = 4,
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned NR_BITS   = 6,
    parameter int unsigned WIS_BITS  = 2,
    localparam int unsigned LOG_BANKS = $clog2(NUM_BANKS),
    localparam int unsigned BANK_W    = (NUM_BANKS > 1) ? LOG_BANKS : 1,
    localparam int unsigned ADDRW     = WIS_BITS + NR_BITS - LOG_BANKS,
    localparam int unsigned WIS_PW    = (WIS_BITS > 0) ? WIS_BITS : 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQS-1:0]           req_valid,
    input  logic [NUM_REQS*WIS_PW-1:0]    req_wis,
    input  logic [NUM_REQS*NR_BITS-1:0]   req_rid,
    output logic [NUM_REQS-1:0]           req_ready,
    output logic [NUM_BANKS-1:0]          bank_rd_en,
    output logic [NUM_BANKS*ADDRW-1:0]    bank_rd_addr,
    output logic [NUM_REQS-1:0]           rsp_valid,
    output logic [NUM_REQS*BANK_W-1:0]    rsp_bank,
    output logic [NUM_REQS-1:0]           rsp_zero,
    output logic [31:0]                   perf_conflicts
);

    localparam int unsigned REQ_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    logic [BANK_W-1:0]          req_bank [NUM_REQS];
    logic [ADDRW-1:0]           req_addr [NUM_REQS];
    logic [NUM_REQS-1:0]        req_zero;
    logic [NUM_REQS-1:0]        req_nz;

    logic [NUM_BANKS-1:0]       gnt_any;
    logic [REQ_W-1:0]           gnt_idx [NUM_BANKS];

    logic [REQ_W-1:0]           rr_ptr_q [NUM_BANKS];
    logic [REQ_W-1:0]           rr_ptr_d [NUM_BANKS];
    logic [REQ_W-1:0]           s1_idx_q [NUM_BANKS];
    logic [REQ_W-1:0]           s1_idx_d [NUM_BANKS];
    logic [NUM_REQS-1:0]        s1_zero_q, s1_zero_d;
    logic [NUM_BANKS-1:0]       rd_en_q, rd_en_d;
    logic [NUM_BANKS*ADDRW-1:0] rd_addr_q, rd_addr_d;
    logic [NUM_REQS-1:0]        rsp_valid_q, rsp_valid_d;
    logic [NUM_REQS*BANK_W-1:0] rsp_bank_q, rsp_bank_d;
    logic [NUM_REQS-1:0]        rsp_zero_q, rsp_zero_d;
    logic [31:0]                perf_q, perf_d;
    logic                       conflict;

    always_comb begin
        for (int unsigned k = 0; k < NUM_REQS; k++) begin
            req_zero[k] = req_valid[k] && (req_rid[k*NR_BITS +: NR_BITS] == '0);
            req_nz[k]   = req_valid[k] && (req_rid[k*NR_BITS +: NR_BITS] != '0);
            req_bank[k] = BANK_W'(32'(req_rid[k*NR_BITS +: NR_BITS]) % NUM_BANKS);
        end
    end

    if (WIS_BITS > 0) begin : g_wis
        always_comb begin
            for (int unsigned k = 0; k < NUM_REQS; k++)
                req_addr[k] = {req_wis[k*WIS_PW +: WIS_PW],
                               req_rid[k*NR_BITS+LOG_BANKS +: NR_BITS-LOG_BANKS]};
        end
    end else begin : g_nowis
        logic unused_wis;
        assign unused_wis = ^req_wis;
        always_comb begin
            for (int unsigned k = 0; k < NUM_REQS; k++)
                req_addr[k] = req_rid[k*NR_BITS+LOG_BANKS +: ADDRW];
        end
    end

    // r0 bypasses the banks entirely, so it is always ready on its own.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_any   = '0;
        req_ready = req_zero;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            gnt_idx[b] = '0;
            for (int unsigned o = 0; o < NUM_REQS; o++) begin
                idx = 32'(rr_ptr_q[b]) + o;
                if (idx >= NUM_REQS)
                    idx = idx - NUM_REQS;
                if (!gnt_any[b] && req_nz[idx] && (32'(req_bank[idx]) == b)) begin
                    gnt_any[b]     = 1'b1;
                    gnt_idx[b]     = REQ_W'(idx);
                    req_ready[idx] = 1'b1;
                end
            end
        end
    end

    assign conflict = |(req_valid & ~req_ready);

    always_comb begin
        rd_en_d     = gnt_any;
        rd_addr_d   = rd_addr_q;
        s1_zero_d   = req_zero;
        rsp_valid_d = s1_zero_q;
        rsp_zero_d  = s1_zero_q;
        rsp_bank_d  = '0;
        perf_d      = (conflict && (perf_q != '1)) ? perf_q + 32'd1 : perf_q;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            rr_ptr_d[b] = rr_ptr_q[b];
            s1_idx_d[b] = gnt_idx[b];
            if (gnt_any[b]) begin
                rr_ptr_d[b] = (32'(gnt_idx[b]) == NUM_REQS - 1) ? '0 : REQ_W'(gnt_idx[b] + 1'b1);
                rd_addr_d[b*ADDRW +: ADDRW] = req_addr[gnt_idx[b]];
            end
            // Response tag follows the bank's read-enable by one cycle (RAM output register).
            if (rd_en_q[b]) begin
                rsp_valid_d[s1_idx_q[b]] = 1'b1;
                rsp_bank_d[32'(s1_idx_q[b])*BANK_W +: BANK_W] = BANK_W'(b);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                rr_ptr_q[b] <= '0;
                s1_idx_q[b] <= '0;
            end
            s1_zero_q   <= '0;
            rd_en_q     <= '0;
            rd_addr_q   <= '0;
            rsp_valid_q <= '0;
            rsp_bank_q  <= '0;
            rsp_zero_q  <= '0;
            perf_q      <= '0;
        end else begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                rr_ptr_q[b] <= rr_ptr_d[b];
                s1_idx_q[b] <= s1_idx_d[b];
            end
            s1_zero_q   <= s1_zero_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_bank_q  <= rsp_bank_d;
            rsp_zero_q  <= rsp_zero_d;
            perf_q      <= perf_d;
        end
    end

    assign bank_rd_en     = rd_en_q;
    assign bank_rd_addr   = rd_addr_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_bank       = rsp_bank_q;
    assign rsp_zero       = rsp_zero_q;
    assign perf_conflicts = perf_q;

endmodule

// File: tb/tb_vx_gpr_bank_scheduler.sv
// Randomized bench for vx_gpr_bank_scheduler against a per-cycle round-robin reference model.
module tb_vx_gpr_bank_scheduler;

    localparam int NR  = 4;
    localparam int NB  = 4;
    localparam int NRB = 6;
    localparam int WB  = 2;
    localparam int BW  = 2;
    localparam int AW  = 6;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NR-1:0]     req_valid;
    logic [NR*WB-1:0]  req_wis;
    logic [NR*NRB-1:0] req_rid;
    logic [NR-1:0]     req_ready;
    logic [NB-1:0]     bank_rd_en;
    logic [NB*AW-1:0]  bank_rd_addr;
    logic [NR-1:0]     rsp_valid;
    logic [NR*BW-1:0]  rsp_bank;
    logic [NR-1:0]     rsp_zero;
    logic [31:0]       perf_conflicts;

    vx_gpr_bank_scheduler #(.NUM_REQS(NR), .NUM_BANKS(NB), .NR_BITS(NRB), .WIS_BITS(WB)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_wis(req_wis),
        .req_rid(req_rid), .req_ready(req_ready), .bank_rd_en(bank_rd_en),
        .bank_rd_addr(bank_rd_addr), .rsp_valid(rsp_valid), .rsp_bank(rsp_bank),
        .rsp_zero(rsp_zero), .perf_conflicts(perf_conflicts)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [NB-1:0]    en;
        logic [NB*AW-1:0] addr;
        logic [NR-1:0]    rv;
        logic [NR-1:0]    rz;
        logic [NR*BW-1:0] rbank;
    } cyc_t;

    // Outstanding request of each requester (held until handshake).
    bit      pend [NR];
    int      p_rid[NR];
    int      p_wis[NR];
    int      ptr  [NB];
    longint  perf;
    int      exp_addr[NB];
    cyc_t    hist[$];

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            ptr[b] = 0;
            exp_addr[b] = 0;
        end
        for (int k = 0; k < NR; k++) pend[k] = 0;
        perf = 0;
        hist.delete();
    endtask

    task automatic cycle(input bit rst);
        cyc_t          r;
        cyc_t          prev;
        logic [NR-1:0] exp_rdy;
        bit            found;
        int            k;
        reset_n = !rst;
        for (int i = 0; i < NR; i++) begin
            req_valid[i]           = pend[i] && !rst;
            req_rid[i*NRB +: NRB]  = NRB'(p_rid[i]);
            req_wis[i*WB +: WB]    = WB'(p_wis[i]);
        end
        #1;
        r = '0;
        exp_rdy = '0;
        if (!rst) begin
            for (int i = 0; i < NR; i++)
                if (pend[i] && p_rid[i] == 0) begin
                    exp_rdy[i] = 1'b1;
                    r.rv[i] = 1'b1;
                    r.rz[i] = 1'b1;
                end
            for (int b = 0; b < NB; b++) begin
                found = 0;
                for (int j = 0; j < NR; j++) begin
                    k = (ptr[b] + j) % NR;
                    if (!found && pend[k] && p_rid[k] != 0 && (p_rid[k] % NB) == b) begin
                        found = 1;
                        exp_rdy[k] = 1'b1;
                        r.en[b] = 1'b1;
                        exp_addr[b] = p_wis[k] * 16 + p_rid[k] / 4;
                        r.rv[k] = 1'b1;
                        r.rbank[k*BW +: BW] = BW'(b);
                        ptr[b] = (k + 1) % NR;
                    end
                end
            end
            check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
            check_eq("perf_conflicts", 64'(perf_conflicts), 64'(perf));
            if (|(req_valid & ~exp_rdy) && perf < 64'hFFFF_FFFF) perf++;
            for (int i = 0; i < NR; i++) if (exp_rdy[i]) pend[i] = 0;
        end
        for (int b = 0; b < NB; b++) r.addr[b*AW +: AW] = AW'(exp_addr[b]);
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
            r = '0;
            check_eq("perf_after_reset", 64'(perf_conflicts), 64'd0);
        end
        hist.push_back(r);
        prev = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
        check_eq("bank_rd_en", 64'(bank_rd_en), 64'(r.en));
        check_eq("bank_rd_addr", 64'(bank_rd_addr), 64'(r.addr));
        check_eq("rsp_valid", 64'(rsp_valid), 64'(prev.rv));
        check_eq("rsp_zero", 64'(rsp_zero), 64'(prev.rz));
        for (int i = 0; i < NR; i++)
            if (prev.rv[i]) check_eq("rsp_bank", 64'(rsp_bank[i*BW +: BW]), 64'(prev.rbank[i*BW +: BW]));
        if (hist.size() > 4) void'(hist.pop_front());
    endtask

    task automatic set_req(input int i, input int rid, input int wis);
        pend[i]  = 1;
        p_rid[i] = rid;
        p_wis[i] = wis;
    endtask

    initial begin
        req_valid = '0;
        req_wis   = '0;
        req_rid   = '0;
        reset_n   = 1'b0;
        for (int i = 0; i < NR; i++) begin
            p_rid[i] = 0;
            p_wis[i] = 0;
        end
        model_reset();
        cycle(1);
        cycle(1);

        // Single request to bank 1.
        set_req(0, 5, 1);
        repeat (3) cycle(0);

        // Two requesters on bank 0.
        set_req(0, 4, 2);
        set_req(1, 8, 3);
        repeat (4) cycle(0);

        // One request per bank in the same cycle.
        for (int i = 0; i < NR; i++) set_req(i, 4 + i, i);
        repeat (3) cycle(0);

        // Everyone hammers bank 2 continuously.
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < NR; i++) if (!pend[i]) set_req(i, 2, i);
            cycle(0);
        end
        for (int i = 0; i < NR; i++) pend[i] = 0;
        repeat (2) cycle(0);

        // r0 alongside bank-0 contention.
        set_req(0, 0, 1);
        set_req(1, 4, 0);
        set_req(2, 8, 0);
        repeat (4) cycle(0);

        // Reset right after a grant.
        set_req(3, 7, 3);
        cycle(0);
        cycle(1);
        cycle(0);
        set_req(0, 12, 1);
        set_req(1, 16, 2);
        repeat (4) cycle(0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NR; i++)
                if (!pend[i] && ($urandom % 3) != 0)
                    set_req(i, (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 15)),
                            int'($urandom % 4));
            if (n % 97 == 96) cycle(1);
            else cycle(0);
        end
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NR; i++)
                if (!pend[i] && ($urandom % 4) != 0)
                    set_req(i, int'($urandom % 64), int'($urandom % 4));
            cycle(0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
